// File: rtl/uart_rx.sv
// Asynchronous serial receiver: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_VOTE_EN to take every bit sample as a 2-of-3 vote over the last three cycles.
module uart_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        serial_i,
  input  logic        two_stop_bits_i,
  input  logic        parity_bit_i,
  input  logic        parity_even_i,
  input  logic [15:0] clock_divider_i,
  output logic [7:0]  data_o,
  output logic        ready_o,
  output logic        parity_error_o,
  output logic        frame_error_o,
  output logic        busy_o
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(4);

  typedef enum logic [2:0] {
    RECOVER,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    FINISH
  } state_t;

  state_t              state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                s;
  logic                sample_c;
  logic [DIV_W-1:0]    eff_div_c;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    bit_idx_q;
  logic [DATA_W-1:0]   shift_q;
  logic                two_stop_q;
  logic                par_en_q;
  logic                par_even_q;
  logic                par_err_q;
  logic                stop_err_q;

  // Metastability chain; resets to the idle line level.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // hist_q holds s from the two cycles before the sample point (counter 2 and 1).
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], s};
    end
  end

  assign sample_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & s) | (hist_q[0] & s);
`else
  assign sample_c = s;
`endif

  // Dividers below 4 (including 0) would underflow the half-bit load.
  assign eff_div_c = (clock_divider_i < MIN_DIV) ? MIN_DIV : clock_divider_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= RECOVER;
      cnt_q          <= '0;
      div_q          <= MIN_DIV;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      two_stop_q     <= 1'b0;
      par_en_q       <= 1'b0;
      par_even_q     <= 1'b0;
      par_err_q      <= 1'b0;
      stop_err_q     <= 1'b0;
      data_o         <= '0;
      ready_o        <= 1'b0;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
      busy_o         <= 1'b1;
    end else begin
      ready_o <= 1'b0;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - DIV_W'(1);
      end

      case (state_q)
        RECOVER: begin
          if (s) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        end

        IDLE: begin
          if (!s) begin
            state_q    <= START;
            busy_o     <= 1'b1;
            cnt_q      <= DIV_W'(eff_div_c >> 1) - DIV_W'(1);
            div_q      <= eff_div_c;
            two_stop_q <= two_stop_bits_i;
            par_en_q   <= parity_bit_i;
            par_even_q <= parity_even_i;
          end
        end

        // Mid-start-bit check rejects short low pulses.
        START: begin
          if (cnt_q == '0) begin
            if (sample_c) begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end else begin
              state_q   <= DATA;
              cnt_q     <= div_q - DIV_W'(1);
              bit_idx_q <= '0;
            end
          end
        end

        DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {sample_c, shift_q[DATA_W-1:1]};
            cnt_q   <= div_q - DIV_W'(1);
            if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
              state_q <= par_en_q ? PARITY : STOP1;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end

        PARITY: begin
          if (cnt_q == '0) begin
            par_err_q <= par_even_q ? (^shift_q ^ sample_c) : ~(^shift_q ^ sample_c);
            cnt_q     <= div_q - DIV_W'(1);
            state_q   <= STOP1;
          end
        end

        STOP1: begin
          if (cnt_q == '0) begin
            stop_err_q <= ~sample_c;
            if (two_stop_q) begin
              cnt_q   <= div_q - DIV_W'(1);
              state_q <= STOP2;
            end else begin
              state_q <= FINISH;
            end
          end
        end

        STOP2: begin
          if (cnt_q == '0) begin
            stop_err_q <= stop_err_q | ~sample_c;
            state_q    <= FINISH;
          end
        end

        // A bad stop bit waits for the line to go high so a break yields one frame.
        FINISH: begin
          ready_o        <= 1'b1;
          data_o         <= shift_q;
          parity_error_o <= par_en_q & par_err_q;
          frame_error_o  <= stop_err_q;
          if (stop_err_q) begin
            state_q <= RECOVER;
          end else begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        end

        default: begin
          state_q <= RECOVER;
          busy_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx;

  localparam int SYNC = 2;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        serial_i = 1'b1;
  logic        two_stop_bits_i = 1'b0;
  logic        parity_bit_i = 1'b0;
  logic        parity_even_i = 1'b0;
  logic [15:0] clock_divider_i = 16'd4;
  logic [7:0]  data_o;
  logic        ready_o;
  logic        parity_error_o;
  logic        frame_error_o;
  logic        busy_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned at;
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
  } pulse_t;

  pulse_t pulses[$];

  uart_rx #(.SYNC_STAGES(SYNC)) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .serial_i        (serial_i),
    .two_stop_bits_i (two_stop_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .clock_divider_i (clock_divider_i),
    .data_o          (data_o),
    .ready_o         (ready_o),
    .parity_error_o  (parity_error_o),
    .frame_error_o   (frame_error_o),
    .busy_o          (busy_o)
  );

  always #5 clock_i = ~clock_i;

  always @(posedge clock_i) cyc <= cyc + 1;

  // Record every strobe with the edge number at which it rose.
  always @(negedge clock_i) begin
    if (ready_o === 1'b1) begin
      pulse_t p;
      p.at   = cyc;
      p.data = data_o;
      p.perr = parity_error_o;
      p.ferr = frame_error_o;
      pulses.push_back(p);
    end
  end

  // Frame-level expectation: arrival time from bit counts, flags from the bits sent.
  function automatic pulse_t model(input int unsigned t0, input int n, input logic [7:0] d,
                                   input bit par_en, input bit par_ok, input bit two_stop,
                                   input bit stop1, input bit stop2);
    pulse_t p;
    int nbits;
    nbits  = 8 + (par_en ? 1 : 0) + (two_stop ? 2 : 1);
    p.at   = t0 + SYNC + n / 2 + n * nbits + 1;
    p.data = d;
    p.perr = par_en && !par_ok;
    p.ferr = !stop1 || (two_stop && !stop2);
    return p;
  endfunction

  // Drives one frame, n cycles per bit; config is scrambled after the start bit.
  task automatic send_frame(input logic [15:0] cfg_div, input int n, input logic [7:0] d,
                            input bit par_en, input bit par_even, input bit par_ok,
                            input bit two_stop, input bit stop1, input bit stop2,
                            input int glitch_at, input int abort_at, output int unsigned t0);
    bit bits[$];
    int ones;
    bit p;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    p = par_even ? (ones % 2 == 1) : (ones % 2 == 0);
    if (!par_ok) p = !p;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_en) bits.push_back(p);
    bits.push_back(stop1);
    if (two_stop) bits.push_back(stop2);
    t0 = 0;
    for (int j = 0; j < bits.size() * n; j++) begin
      @(negedge clock_i);
      if (j == abort_at) begin
        reset_i  = 1'b1;
        serial_i = 1'b1;
        return;
      end
      if (j == 0) begin
        clock_divider_i = cfg_div;
        two_stop_bits_i = two_stop;
        parity_bit_i    = par_en;
        parity_even_i   = par_even;
        t0 = cyc + 1;
      end else if (j == n) begin
        clock_divider_i = 16'($urandom);
        two_stop_bits_i = 1'($urandom);
        parity_bit_i    = 1'($urandom);
        parity_even_i   = 1'($urandom);
      end
      serial_i = bits[j / n] ^ (j == glitch_at);
    end
  endtask

  task automatic idle(input int k);
    serial_i = 1'b1;
    repeat (k) @(negedge clock_i);
  endtask

  task automatic test_reset();
    int k;
    reset_i  = 1'b1;
    serial_i = 1'b1;
    repeat (3) @(negedge clock_i);
    vectors++;
    if (busy_o !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy_o); end
    vectors++;
    if (data_o !== 8'h00 || ready_o !== 1'b0 || parity_error_o !== 1'b0 || frame_error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h rdy=%b pe=%b fe=%b want 00 0 0 0",
               data_o, ready_o, parity_error_o, frame_error_o);
    end
    reset_i = 1'b0;
    k = 0;
    while (busy_o !== 1'b0 && k < 20) begin @(negedge clock_i); k++; end
    vectors++;
    if (k > SYNC + 2) begin miscompares++; $display("FAIL reset_release: busy fell after %0d want <= %0d", k, SYNC + 2); end
    idle(4);
    vectors++;
    if (pulses.size() != 0 || data_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_quiet: got %0d pulses data=%h want 0 pulses data=00", pulses.size(), data_o);
    end
  endtask

  task automatic test_basic();
    int unsigned t0;
    pulse_t e;
    pulses.delete();
    send_frame(16'd4, 4, 8'h55, 0, 0, 1, 0, 1, 1, -1, -1, t0);
    idle(12);
    e = model(t0, 4, 8'h55, 0, 1, 0, 1, 1);
    vectors++;
    if (pulses.size() != 1) begin miscompares++; $display("FAIL basic_count: got %0d want 1", pulses.size()); end
    else begin
      vectors++;
      if (pulses[0].at - t0 != 41) begin miscompares++; $display("FAIL basic_latency: got %0d want 41", pulses[0].at - t0); end
      vectors++;
      if (pulses[0].data !== e.data || pulses[0].perr !== 1'b0 || pulses[0].ferr !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_data: got %h pe=%b fe=%b want %h 0 0", pulses[0].data, pulses[0].perr, pulses[0].ferr, e.data);
      end
    end
  endtask

  task automatic test_parity();
    int unsigned t0;
    pulse_t e;
    for (int pass = 0; pass < 2; pass++) begin
      pulses.delete();
      send_frame(16'd8, 8, 8'hA3, 1, 1, pass == 0, 1, 1, 1, -1, -1, t0);
      idle(24);
      e = model(t0, 8, 8'hA3, 1, pass == 0, 1, 1, 1);
      vectors++;
      if (pulses.size() != 1) begin miscompares++; $display("FAIL parity_count[%0d]: got %0d want 1", pass, pulses.size()); end
      else begin
        vectors++;
        if (pulses[0].at !== e.at || pulses[0].data !== e.data || pulses[0].perr !== e.perr || pulses[0].ferr !== e.ferr) begin
          miscompares++;
          $display("FAIL parity[%0d]: got at=%0d %h pe=%b fe=%b want at=%0d %h pe=%b fe=%b", pass,
                   pulses[0].at, pulses[0].data, pulses[0].perr, pulses[0].ferr, e.at, e.data, e.perr, e.ferr);
        end
      end
    end
  endtask

  task automatic test_break();
    int unsigned t0;
    int k;
    pulse_t e;
    pulses.delete();
    send_frame(16'd4, 4, 8'h0F, 0, 0, 1, 0, 0, 1, -1, -1, t0);
    serial_i = 1'b0;
    repeat (40) @(negedge clock_i);
    e = model(t0, 4, 8'h0F, 0, 1, 0, 0, 1);
    vectors++;
    if (pulses.size() != 1) begin miscompares++; $display("FAIL break_count: got %0d want 1", pulses.size()); end
    else begin
      vectors++;
      if (pulses[0].at !== e.at || pulses[0].data !== 8'h0F || pulses[0].ferr !== 1'b1 || pulses[0].perr !== 1'b0) begin
        miscompares++;
        $display("FAIL break_frame: got at=%0d %h pe=%b fe=%b want at=%0d 0f 0 1",
                 pulses[0].at, pulses[0].data, pulses[0].perr, pulses[0].ferr, e.at);
      end
    end
    vectors++;
    if (busy_o !== 1'b1) begin miscompares++; $display("FAIL break_busy: got %b want 1", busy_o); end
    serial_i = 1'b1;
    k = 0;
    while (busy_o !== 1'b0 && k < 20) begin @(negedge clock_i); k++; end
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL break_recover: busy got %b want 0", busy_o); end
    pulses.delete();
    send_frame(16'd4, 4, 8'h3C, 0, 0, 1, 0, 1, 1, -1, -1, t0);
    idle(12);
    vectors++;
    if (pulses.size() != 1 || pulses[0].data !== 8'h3C || pulses[0].ferr !== 1'b0) begin
      miscompares++;
      $display("FAIL break_next: got %0d pulses data=%h fe=%b want 1 3c 0", pulses.size(), data_o, frame_error_o);
    end
  endtask

  task automatic test_false_start();
    int k;
    pulses.delete();
    clock_divider_i = 16'd8;
    @(negedge clock_i); serial_i = 1'b0;
    @(negedge clock_i); serial_i = 1'b0;
    @(negedge clock_i); serial_i = 1'b1;
    k = 0;
    repeat (30) @(negedge clock_i);
    vectors++;
    if (pulses.size() != 0) begin miscompares++; $display("FAIL false_start_strobe: got %0d pulses want 0", pulses.size()); end
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL false_start_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_reset_midframe();
    int unsigned t0;
    int k;
    pulses.delete();
    send_frame(16'd4, 4, 8'h81, 0, 0, 1, 0, 1, 1, -1, 17, t0);
    repeat (2) @(negedge clock_i);
    vectors++;
    if (data_o !== 8'h00 || ready_o !== 1'b0 || parity_error_o !== 1'b0 || frame_error_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_outputs: got data=%h rdy=%b pe=%b fe=%b busy=%b want 00 0 0 0 1",
               data_o, ready_o, parity_error_o, frame_error_o, busy_o);
    end
    reset_i = 1'b0;
    k = 0;
    while (busy_o !== 1'b0 && k < 20) begin @(negedge clock_i); k++; end
    idle(50);
    vectors++;
    if (pulses.size() != 0) begin miscompares++; $display("FAIL midreset_strobe: got %0d pulses want 0", pulses.size()); end
    pulses.delete();
    send_frame(16'd4, 4, 8'hC6, 0, 0, 1, 0, 1, 1, -1, -1, t0);
    idle(12);
    vectors++;
    if (pulses.size() != 1 || pulses[0].data !== 8'hC6 || pulses[0].at != t0 + 41) begin
      miscompares++;
      $display("FAIL midreset_next: got %0d pulses data=%h want 1 c6 at +41", pulses.size(), data_o);
    end
  endtask

  task automatic test_glitch();
    int unsigned t0;
    logic [7:0] want;
`ifdef UART_RX_MAJORITY_VOTE_EN
    want = 8'h00;
`else
    want = 8'h04;
`endif
    pulses.delete();
    send_frame(16'd8, 8, 8'h00, 0, 0, 1, 0, 1, 1, 8 / 2 + 8 * 3, -1, t0);
    idle(24);
    vectors++;
    if (pulses.size() != 1 || pulses[0].data !== want) begin
      miscompares++;
      $display("FAIL glitch: got %0d pulses data=%h want 1 %h", pulses.size(), data_o, want);
    end
  endtask

  task automatic test_divider_zero();
    int unsigned t0;
    pulses.delete();
    send_frame(16'd0, 4, 8'h9A, 0, 0, 1, 0, 1, 1, -1, -1, t0);
    idle(12);
    vectors++;
    if (pulses.size() != 1 || pulses[0].data !== 8'h9A || pulses[0].at != t0 + 41) begin
      miscompares++;
      $display("FAIL div_zero: got %0d pulses data=%h want 1 9a at +41", pulses.size(), data_o);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned t0s[4];
    logic [7:0] ds[4];
    int n;
    bit pe, pev, ts;
    pulse_t e;
    n   = int'($urandom_range(4, 10));
    pe  = 1'($urandom);
    pev = 1'($urandom);
    ts  = 1'($urandom);
    pulses.delete();
    for (int f = 0; f < 4; f++) begin
      ds[f] = 8'($urandom);
      send_frame(16'(n), n, ds[f], pe, pev, 1, ts, 1, 1, -1, -1, t0s[f]);
    end
    idle(3 * n + 10);
    vectors++;
    if (pulses.size() != 4) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", pulses.size()); end
    else begin
      for (int f = 0; f < 4; f++) begin
        e = model(t0s[f], n, ds[f], pe, 1, ts, 1, 1);
        vectors++;
        if (pulses[f].at !== e.at || pulses[f].data !== e.data || pulses[f].perr !== e.perr || pulses[f].ferr !== e.ferr) begin
          miscompares++;
          $display("FAIL b2b[%0d]: got at=%0d %h pe=%b fe=%b want at=%0d %h pe=%b fe=%b", f,
                   pulses[f].at, pulses[f].data, pulses[f].perr, pulses[f].ferr, e.at, e.data, e.perr, e.ferr);
        end
      end
    end
  endtask

  task automatic test_random();
    int unsigned t0;
    int n;
    logic [7:0] d;
    bit pe, pev, pok, ts, s1, s2;
    pulse_t e;
    for (int f = 0; f < 20; f++) begin
      n   = int'($urandom_range(4, 16));
      d   = 8'($urandom);
      pe  = 1'($urandom);
      pev = 1'($urandom);
      pok = ($urandom_range(0, 3) != 0);
      ts  = 1'($urandom);
      s1  = ($urandom_range(0, 4) != 0);
      s2  = ($urandom_range(0, 4) != 0);
      pulses.delete();
      send_frame(16'(n), n, d, pe, pev, pok, ts, s1, s2, -1, -1, t0);
      idle(2 * n + SYNC + 8);
      e = model(t0, n, d, pe, pok, ts, s1, s2);
      vectors++;
      if (pulses.size() != 1) begin miscompares++; $display("FAIL rand_count[%0d]: got %0d want 1", f, pulses.size()); end
      else begin
        vectors++;
        if (pulses[0].at !== e.at || pulses[0].data !== e.data || pulses[0].perr !== e.perr || pulses[0].ferr !== e.ferr) begin
          miscompares++;
          $display("FAIL rand[%0d]: got at=%0d %h pe=%b fe=%b want at=%0d %h pe=%b fe=%b", f,
                   pulses[0].at, pulses[0].data, pulses[0].perr, pulses[0].ferr, e.at, e.data, e.perr, e.ferr);
        end
        vectors++;
        if (data_o !== e.data || busy_o !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_hold[%0d]: got data=%h busy=%b want %h 0", f, data_o, busy_o, e.data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_false_start();
    test_reset_midframe();
    test_glitch();
    test_divider_zero();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver. It is the receive-side counterpart of UartTx and shares its frame format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Oversamples serial_i with the system clock, using the same clock_divider_i bit-period convention as the transmitter.
- Delivers each received byte with a one-cycle ready strobe plus parity and framing status.

Parameters:
- SYNC_STAGES, 2, number of flops in the serial_i synchroniser chain; legal range 2..4.

Ports:
- clock_i  input  1  system clock; all logic is on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- serial_i  input  1  serial line; idles high; asynchronous to clock_i.
- two_stop_bits_i  input  1  1 = frame has two stop bits.
- parity_bit_i  input  1  1 = frame has a parity bit.
- parity_even_i  input  1  1 = even parity, 0 = odd parity.
- clock_divider_i  input  16  bit period N, in clock_i cycles.
- data_o  output  8  last received byte.
- ready_o  output  1  one-cycle strobe: data_o and the error flags are updated.
- parity_error_o  output  1  parity mismatch in the last frame.
- frame_error_o  output  1  a stop bit was sampled low in the last frame.
- busy_o  output  1  receiver is not idle.

Behaviour:
- Reset: data_o = 0x00, ready_o = 0, parity_error_o = 0, frame_error_o = 0, busy_o = 1.
  - The state machine enters RECOVER.
  - All synchroniser flops reset to 1.
- Synchroniser: serial_i passes through SYNC_STAGES flops to give s. All decisions use s.
- Configuration latching:
  - N, two_stop_bits_i, parity_bit_i and parity_even_i are latched on the IDLE->START transition.
  - Input changes mid-frame have no effect on the current frame.
- Divider range:
  - Supported N is 4..65535.
  - N < 4 is unsupported; N = 0 must not hang the receiver (treat as 4).
- busy_o = 1 in every state except IDLE.
- Bit counter: a single down-counter times each phase. Sample point = the cycle the counter reaches 0.
- States and transitions:
  - RECOVER: wait until s = 1, then go to IDLE.
  - IDLE: if s = 0, go to START and load counter = floor(N/2) - 1.
  - START: at the sample point:
    - s = 1: false start; go to IDLE. No strobe, flags unchanged.
    - s = 0: go to DATA, load counter = N - 1, bit index = 0.
  - DATA: at each sample point, shift s into bit[index], LSB first, and reload N - 1. After bit 7 go to PARITY if parity is enabled, else STOP1.
  - PARITY: at the sample point, capture the parity bit p.
    - Even parity: error = ^data ^ p.
    - Odd parity: error = ~(^data ^ p).
    - Then go to STOP1.
  - STOP1: at the sample point, record the stop bit. If two stop bits, go to STOP2; else finish.
  - STOP2: at the sample point, record the stop bit, then finish.
- Finish (next cycle):
  - ready_o = 1 for exactly one cycle.
  - data_o, parity_error_o and frame_error_o update in that same cycle and hold until the next finished frame.
  - parity_error_o = 0 when parity is disabled.
  - frame_error_o = 1 if any stop sample was 0; the next state is then RECOVER, so a break or stuck-low line yields exactly one frame, not a stream of 0x00.
  - Otherwise the next state is IDLE.
- Latency: ready_o rises SYNC_STAGES + floor(N/2) + N*(8 + P + S) + 1 cycles after the first rising edge at which serial_i is low.
  - P = 1 if parity is enabled, else 0.
  - S = 1 or 2 stop bits.
- Back-to-back frames: a start bit beginning immediately after the stop bit is received without loss.
- Reset asserted mid-frame aborts immediately. No strobe is issued; outputs take their reset values.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: every sample point (start, data, parity, stop) uses the 2-of-3 majority of s at the counter values 2, 1 and 0. This rejects a single-cycle glitch within the window. Latency is unchanged.
- Undefined: a single sample of s at counter = 0.

Test Plan:
- Reset, serial_i = 1 -> busy_o = 1 during reset; busy_o falls within SYNC_STAGES + 2 cycles of release; data_o = 0x00; no ready_o.
- N = 4, no parity, 1 stop, drive 0x55 -> one ready_o pulse 41 cycles after the start edge; data_o = 0x55; both error flags = 0.
- N = 8, even parity, 2 stop bits, send 0xA3 with correct parity bit 0 -> data_o = 0xA3, parity_error_o = 0. Repeat with parity bit 1 -> parity_error_o = 1.
- N = 4, send 0x0F with stop bit 0, then hold the line low for 40 cycles -> exactly one ready_o with frame_error_o = 1; busy_o stays 1 until the line returns high; the next frame 0x3C is received cleanly.
- N = 8, 2-cycle low pulse on an idle line -> false start; no ready_o; busy_o returns to 0.
- N = 4, reset asserted during bit 3 of a frame -> no ready_o; outputs at reset values. A subsequent frame 0xC6 is received correctly.
- With UART_RX_MAJORITY_VOTE_EN, N = 8, inject a 1-cycle inverted glitch at the data bit 2 sample point of 0x00 -> data_o = 0x00. Without the macro -> data_o = 0x04.
